mem_stage: RTL



---
 rtl/mem_stage_pkg.sv | 20 ++
 rtl/mem_stage_load_align.sv | 27 ++
 rtl/mem_stage.sv | 94 +++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: bus widths, load/store access encodings
// and the data-response state encoding.
package mem_stage_pkg;

  localparam int EXE_TO_MEM_BUS_WIDTH = 75;
  localparam int MEM_TO_WB_BUS_WIDTH  = 70;

  localparam logic [2:0] MEM_OP_W  = 3'b000;
  localparam logic [2:0] MEM_OP_B  = 3'b001;
  localparam logic [2:0] MEM_OP_H  = 3'b010;
  localparam logic [2:0] MEM_OP_BU = 3'b101;
  localparam logic [2:0] MEM_OP_HU = 3'b110;

  typedef enum logic [1:0] {
    MEM_S_IDLE = 2'b00,
    MEM_S_WAIT = 2'b01,
    MEM_S_HOLD = 2'b10
  } mem_state_e;

endpackage

// File: rtl/mem_stage_load_align.sv
// Selects the addressed byte/half of a 32-bit read word and sign- or zero-extends it;
// unlisted encodings fall back to the whole word.
module load_align
  import mem_stage_pkg::*;
(
  input  logic [2:0]  mem_op,
  input  logic [1:0]  addr,
  input  logic [31:0] rdata,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{addr, 3'b000} +: 8];
    half_sel = rdata[{addr[1], 4'b0000} +: 16];
    case (mem_op)
      MEM_OP_B:  result = {{24{byte_sel[7]}}, byte_sel};
      MEM_OP_BU: result = {24'd0, byte_sel};
      MEM_OP_H:  result = {{16{half_sel[15]}}, half_sel};
      MEM_OP_HU: result = {16'd0, half_sel};
      default:   result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: holds the EXE->MEM bus, waits for the data-SRAM response,
// buffers it while WB stalls, and presents the aligned result to WB and ID.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                            clk,
  input  logic                            resetn,
  input  logic                            exe_to_mem_valid,
  output logic                            mem_allow_in,
  input  logic [EXE_TO_MEM_BUS_WIDTH-1:0] exe_to_mem_bus,
  input  logic                            wb_allow_in,
  output logic                            mem_to_wb_valid,
  output logic [MEM_TO_WB_BUS_WIDTH-1:0]  mem_to_wb_bus,
  input  logic                            data_sram_data_ok,
  input  logic [31:0]                     data_sram_rdata,
  output logic                            mem_valid,
  output logic                            mem_rf_we,
  output logic [4:0]                      mem_rf_waddr,
  output logic                            mem_fwd_ok,
  output logic [31:0]                     mem_fwd_data
);

  logic [EXE_TO_MEM_BUS_WIDTH-1:0] exe_bus_r;
  logic [31:0] pc;
  logic [31:0] alu_result;
  logic        res_from_mem;
  logic [2:0]  mem_op;
  logic        req_sent;
  logic        reg_we;
  logic [4:0]  reg_waddr;

  mem_state_e  state;
  mem_state_e  next_state;
  logic [31:0] rdata_buf;
  logic [31:0] load_src;
  logic [31:0] aligned_load;
  logic [31:0] final_result;
  logic        ready_go;

  assign {pc, alu_result, res_from_mem, mem_op, req_sent, reg_we, reg_waddr} = exe_bus_r;

  assign ready_go = (state == MEM_S_IDLE) || (state == MEM_S_HOLD) ||
                    ((state == MEM_S_WAIT) && data_sram_data_ok);
  assign mem_allow_in    = !mem_valid || (ready_go && wb_allow_in);
  assign mem_to_wb_valid = mem_valid && ready_go;

  // Leaving the stage always restarts the FSM from the incoming instruction;
  // otherwise only a response that WB cannot take yet moves WAIT to HOLD.
  always_comb begin
    next_state = state;
    if (mem_allow_in) begin
      next_state = (exe_to_mem_valid && exe_to_mem_bus[6]) ? MEM_S_WAIT : MEM_S_IDLE;
    end else if ((state == MEM_S_WAIT) && data_sram_data_ok) begin
      next_state = MEM_S_HOLD;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= MEM_S_IDLE;
      mem_valid <= 1'b0;
      exe_bus_r <= '0;
      rdata_buf <= '0;
    end else begin
      state <= next_state;
      if (mem_allow_in) begin
        mem_valid <= exe_to_mem_valid;
      end
      if (mem_allow_in && exe_to_mem_valid) begin
        exe_bus_r <= exe_to_mem_bus;
      end
      if ((state == MEM_S_WAIT) && (next_state == MEM_S_HOLD)) begin
        rdata_buf <= data_sram_rdata;
      end
    end
  end

  assign load_src = (state == MEM_S_HOLD) ? rdata_buf : data_sram_rdata;

  load_align u_load_align (
    .mem_op (mem_op),
    .addr   (alu_result[1:0]),
    .rdata  (load_src),
    .result (aligned_load)
  );

  assign final_result  = res_from_mem ? aligned_load : alu_result;
  assign mem_to_wb_bus = {pc, final_result, reg_we, reg_waddr};
  assign mem_rf_we     = reg_we && mem_valid;
  assign mem_rf_waddr  = reg_waddr;
  assign mem_fwd_ok    = mem_valid && ready_go;
  assign mem_fwd_data  = final_result;

endmodule
